serial_magnitude_comparator: RTL and testbench

SERIAL_MAGNITUDE_COMPARATOR -- requirements
Module: serial_magnitude_comparator

---
 rtl/comparator_pkg.sv | 18 +
 rtl/compare_bit_slice.sv | 26 ++
 rtl/serial_magnitude_comparator.sv | 120 ++++++++++++
 tb/tb_serial_magnitude_comparator.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/comparator_pkg.sv
// Shared types for the serial magnitude comparator: FSM states and the
// internal 2-bit comparison decision encoding.
package comparator_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    GT   = 2'b01,
    LT   = 2'b10,
    EQ   = 2'b11
  } result_t;

endpackage

// File: rtl/compare_bit_slice.sv
// One MSB-first comparison step: the first differing bit pair decides,
// and an existing decision is carried through unchanged.
module compare_bit_slice
  import comparator_pkg::*;
(
  input  logic    a_bit,
  input  logic    b_bit,
  input  result_t dec_in,
  output result_t dec_out
);

  // next decision from the current bit pair
  always_comb begin
    dec_out = dec_in;
    if (dec_in == NONE) begin
      case ({a_bit, b_bit})
        2'b10:   dec_out = GT;
        2'b01:   dec_out = LT;
        default: dec_out = NONE;
      endcase
    end else begin
      dec_out = dec_in;
    end
  end

endmodule

// File: rtl/serial_magnitude_comparator.sv
// Bit-serial unsigned magnitude comparator with valid/ready handshakes.
// Define SERIAL_CMP_EARLY_EXIT_EN to finish as soon as the first differing bit is seen.
module serial_magnitude_comparator
  import comparator_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             Greater,
  output logic             Less,
  output logic             Equal
);

  localparam int CW = $clog2(WIDTH);

  state_t           state_r;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [CW-1:0]    cnt_r;
  result_t          dec_r;
  result_t          dec_next_s;
  result_t          final_s;
  logic             done_now_s;
  logic             last_bit_s;

  // Decoded from the state register so the first edge after reset can accept.
  assign in_ready = (state_r == IDLE) && !reset;

  compare_bit_slice u_slice (
    .a_bit   (a_sh_r[WIDTH-1]),
    .b_bit   (b_sh_r[WIDTH-1]),
    .dec_in  (dec_r),
    .dec_out (dec_next_s)
  );

  // completion condition and final result for the current SHIFT cycle
  always_comb begin
    last_bit_s = (cnt_r == {CW{1'b0}});
    final_s    = (dec_next_s == NONE) ? EQ : dec_next_s;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    done_now_s = last_bit_s || (dec_next_s != NONE);
`else
    done_now_s = last_bit_s;
`endif
  end

  // FSM, operand shift registers, bit counter and registered result flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      a_sh_r    <= {WIDTH{1'b0}};
      b_sh_r    <= {WIDTH{1'b0}};
      cnt_r     <= {CW{1'b0}};
      dec_r     <= NONE;
      out_valid <= 1'b0;
      Greater   <= 1'b0;
      Less      <= 1'b0;
      Equal     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_sh_r  <= A;
            b_sh_r  <= B;
            cnt_r   <= CW'(WIDTH - 1);
            dec_r   <= NONE;
            state_r <= SHIFT;
          end else begin
            state_r <= IDLE;
          end
        end
        SHIFT: begin
          a_sh_r <= {a_sh_r[WIDTH-2:0], 1'b0};
          b_sh_r <= {b_sh_r[WIDTH-2:0], 1'b0};
          dec_r  <= dec_next_s;
          if (!last_bit_s) begin
            cnt_r <= cnt_r - CW'(1);
          end else begin
            cnt_r <= cnt_r;
          end
          if (done_now_s) begin
            state_r   <= DONE;
            out_valid <= 1'b1;
            Greater   <= (final_s == GT);
            Less      <= (final_s == LT);
            Equal     <= (final_s == EQ);
          end else begin
            state_r <= SHIFT;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_r   <= IDLE;
            out_valid <= 1'b0;
            Greater   <= 1'b0;
            Less      <= 1'b0;
            Equal     <= 1'b0;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          state_r   <= IDLE;
          out_valid <= 1'b0;
          Greater   <= 1'b0;
          Less      <= 1'b0;
          Equal     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Directed self-checking bench for serial_magnitude_comparator (WIDTH=8);
// latency expectations follow SERIAL_CMP_EARLY_EXIT_EN when it is defined.
module tb_serial_magnitude_comparator;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] A = 8'd0;
  logic [7:0] B = 8'd0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       Greater;
  logic       Less;
  logic       Equal;

  int checks = 0;
  int errors = 0;

  serial_magnitude_comparator #(.WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Greater   (Greater),
    .Less      (Less),
    .Equal     (Equal)
  );

  always #5 clk = ~clk;

`ifdef SERIAL_CMP_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  function automatic int exp_lat(input logic [7:0] a, input logic [7:0] b);
    if (EARLY) begin
      for (int i = 7; i >= 0; i--) begin
        if (a[i] != b[i]) return 8 - i;
      end
    end
    return 8;
  endfunction

  // Presents a pair, accepts it, scrambles the inputs, and counts edges to out_valid.
  task automatic run_accept(input logic [7:0] a, input logic [7:0] b,
                            output int lat, output bit ir_seen);
    A = a; B = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; A = ~a; B = ~b;
    lat = -1; ir_seen = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      if (out_valid) begin lat = i - 1; break; end
      if (in_ready) ir_seen = 1'b1;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, out_valid, Greater, Less, Equal} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 00000", {in_ready, out_valid, Greater, Less, Equal});
    end
    reset = 1'b0; in_valid = 1'b1; A = 8'd5; B = 8'd3;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b expected 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL first_accept: in_ready got %b expected 0", in_ready); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
  endtask

  task automatic test_equal();
    int lat; bit irs;
    run_accept(8'd100, 8'd100, lat, irs);
    checks++;
    if (lat !== 8) begin errors++; $display("FAIL equal_latency: got %0d expected 8", lat); end
    checks++;
    if ({Greater, Less, Equal} !== 3'b001) begin errors++; $display("FAIL equal_flags: got %b expected 001", {Greater, Less, Equal}); end
    checks++;
    if (irs !== 1'b0) begin errors++; $display("FAIL equal_ready_busy: in_ready seen high got %b expected 0", irs); end
    out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
    checks++;
    if ({out_valid, Greater, Less, Equal, in_ready} !== 5'b00001) begin
      errors++; $display("FAIL equal_release: got %b expected 00001", {out_valid, Greater, Less, Equal, in_ready});
    end
  endtask

  task automatic test_simple(input string name, input logic [7:0] a, input logic [7:0] b,
                             input int lat_exp, input logic [2:0] flags_exp);
    int lat; bit irs;
    run_accept(a, b, lat, irs);
    checks++;
    if (lat !== lat_exp) begin errors++; $display("FAIL %s_latency: got %0d expected %0d", name, lat, lat_exp); end
    checks++;
    if ({Greater, Less, Equal} !== flags_exp) begin errors++; $display("FAIL %s_flags: got %b expected %b", name, {Greater, Less, Equal}, flags_exp); end
    out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int lat; bit irs;
    run_accept(8'd235, 8'd200, lat, irs);
    checks++;
    if (lat !== (EARLY ? 3 : 8)) begin errors++; $display("FAIL bp_latency: got %0d expected %0d", lat, EARLY ? 3 : 8); end
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      checks++;
      if ({out_valid, Greater, Less, Equal, in_ready} !== 5'b11000) begin
        errors++; $display("FAIL bp_hold cycle %0d: got %b expected 11000", c, {out_valid, Greater, Less, Equal, in_ready});
      end
    end
    out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
    checks++;
    if ({out_valid, Greater, in_ready} !== 3'b001) begin
      errors++; $display("FAIL bp_release: got %b expected 001", {out_valid, Greater, in_ready});
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    A = 8'd99; B = 8'd100; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({in_ready, out_valid, Greater, Less, Equal} !== 5'b0) begin
      errors++; $display("FAIL midreset_outputs: got %b expected 00000", {in_ready, out_valid, Greater, Less, Equal});
    end
    reset = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL midreset_ready: got %b expected 1", in_ready); end
    seen = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (out_valid || Greater || Less || Equal) seen = 1'b1;
    end
    out_ready = 1'b0;
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL midreset_no_result: got %b expected 0", seen); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] pa [15] = '{8'd255, 8'd6, 8'd0, 8'd1, 8'd0, 8'd128, 8'd127, 8'd170,
                           8'd85, 8'd200, 8'd17, 8'd254, 8'd64, 8'd3, 8'd9};
    logic [7:0] pb [15] = '{8'd255, 8'd6, 8'd0, 8'd0, 8'd1, 8'd127, 8'd128, 8'd85,
                           8'd170, 8'd201, 8'd17, 8'd255, 8'd64, 8'd2, 8'd200};
    logic [2:0] fexp;
    int lat;
    out_ready = 1'b1;
    A = pa[0]; B = pb[0]; in_valid = 1'b1;
    for (int p = 0; p < 15; p++) begin
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d]: got %b expected 1", p, in_ready); end
      @(posedge clk); #1;
      if (p < 14) begin A = pa[p+1]; B = pb[p+1]; end else in_valid = 1'b0;
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
        if (out_valid) begin lat = i - 1; break; end
        @(posedge clk); #1;
      end
      fexp = {pa[p] > pb[p], pa[p] < pb[p], pa[p] == pb[p]};
      checks++;
      if ({Greater, Less, Equal} !== fexp || lat !== exp_lat(pa[p], pb[p])) begin
        errors++;
        $display("FAIL b2b[%0d] %0d/%0d: flags %b lat %0d expected flags %b lat %0d",
                 p, pa[p], pb[p], {Greater, Less, Equal}, lat, fexp, exp_lat(pa[p], pb[p]));
      end
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_done_ready[%0d]: got %b expected 0", p, in_ready); end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_release[%0d]: got %b expected 0", p, out_valid); end
    end
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_equal();
    test_simple("less_50_60", 8'd50, 8'd60, EARLY ? 5 : 8, 3'b010);
    test_simple("greater_32_31", 8'd32, 8'd31, EARLY ? 3 : 8, 3'b100);
    test_simple("less_0_255", 8'd0, 8'd255, EARLY ? 1 : 8, 3'b010);
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
